// File: rtl/reg_seq_pkg.sv
// reg_seq_pkg: shared op/state encodings and register-pair index constants
package reg_seq_pkg;
  typedef enum logic [1:0] {MOVE = 2'd0, INC = 2'd1, DEC = 2'd2, SWAP = 2'd3} op_e;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B} state_e;
  localparam int REG_BC = 0;
  localparam int REG_DE = 1;
  localparam int REG_HL = 2;
  localparam int REG_SP = 3;
  localparam int REG_PC = 4;
  localparam int REG_WZ = 5;
endpackage

// File: rtl/reg_pair_incdec.sv
// reg_pair_incdec: combinational +1 / -1 / pass-through, wrapping modulo 2^DATA_W
module reg_pair_incdec
  import reg_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  output logic [DATA_W-1:0] y_o
);
  always_comb y_o = (op_i == INC) ? a_i + DATA_W'(1) : (op_i == DEC) ? a_i - DATA_W'(1) : a_i;
endmodule

// File: rtl/reg_pair_sequencer.sv
// reg_pair_sequencer: sequences read/write strobes on the register-pair latch bus
module reg_pair_sequencer
  import reg_seq_pkg::*;
#(
  parameter int NUM_REGS = 6,
  parameter int DATA_W   = 16,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                clk50M_i,
  input  logic                rst_ni,
  input  logic                op_valid_i,
  output logic                op_ready_o,
  input  op_e                 op_code_i,
  input  logic [IDX_W-1:0]    src_idx_i,
  input  logic [IDX_W-1:0]    dst_idx_i,
  output logic [NUM_REGS-1:0] latch_rd_o,
  output logic [NUM_REGS-1:0] latch_wr_o,
  input  logic [DATA_W-1:0]   bus_i,
  output logic [DATA_W-1:0]   bus_o,
  output logic                done_o,
  output logic                err_o
);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [IDX_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [DATA_W-1:0] temp_a_q, temp_a_d, temp_b_q, temp_b_d, incdec_y;
  logic done_q, done_d, err_q, err_d, accept, bad_idx;
  reg_pair_incdec #(.DATA_W(DATA_W)) u_incdec (.op_i(op_q), .a_i(temp_a_q), .y_o(incdec_y));
  assign op_ready_o = state_q == IDLE;
  assign accept = op_valid_i & op_ready_o;
  // dst only matters for ops that actually use it
  assign bad_idx = (int'(src_idx_i) >= NUM_REGS) ||
                   ((op_code_i == MOVE || op_code_i == SWAP) && int'(dst_idx_i) >= NUM_REGS);
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src_d    = src_q;
    dst_d    = dst_q;
    temp_a_d = temp_a_q;
    temp_b_d = temp_b_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        op_d    = op_code_i;
        src_d   = src_idx_i;
        dst_d   = dst_idx_i;
        err_d   = bad_idx;
        state_d = bad_idx ? IDLE : RD_A;
      end
      RD_A: begin
        temp_a_d = bus_i;
        state_d  = (op_q == MOVE) ? WR_B : (op_q == SWAP) ? RD_B : WR_A;
      end
      RD_B: begin
        temp_b_d = bus_i;
        state_d  = WR_A;
      end
      WR_A: begin
        state_d = (op_q == SWAP) ? WR_B : IDLE;
        done_d  = op_q != SWAP;
      end
      WR_B: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= MOVE;
      src_q    <= '0;
      dst_q    <= '0;
      temp_a_q <= '0;
      temp_b_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      temp_a_q <= temp_a_d;
      temp_b_q <= temp_b_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  assign latch_rd_o = (state_q == RD_A) ? NUM_REGS'(1) << src_q :
                      (state_q == RD_B) ? NUM_REGS'(1) << dst_q : '0;
  assign latch_wr_o = (state_q == WR_A) ? NUM_REGS'(1) << src_q :
                      (state_q == WR_B) ? NUM_REGS'(1) << dst_q : '0;
  assign bus_o = (state_q == WR_A) ? ((op_q == SWAP) ? temp_b_q : incdec_y) :
                 (state_q == WR_B) ? temp_a_q : '0;
  assign done_o = done_q;
  assign err_o  = err_q;
endmodule
